pipeline_sequencer: RTL and testbench



---
 rtl/pipeline_pkg.sv | 39 +++
 rtl/pipeline_sequencer_if.sv | 35 +++
 rtl/sat_counter.sv | 22 ++
 rtl/pipeline_sequencer.sv | 88 ++++++++
 tb/tb_pipeline_sequencer.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline sequencer: FSM encoding, default
// mult/div latency and the bundle of pipeline-register control bits.
package pipeline_pkg;

  typedef enum logic {
    RUN = 1'b0,
    MDU = 1'b1
  } state_t;

  localparam int MDU_CYCLES_DEFAULT = 4;

  // Enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
  } pipe_ctrl_t;

  // Everything advances, nothing is cleared.
  localparam pipe_ctrl_t CTRL_RUN = '{
    pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
    idex_flush: 1'b0, exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1
  };

  // Whole pipeline frozen while data memory is not ready.
  localparam pipe_ctrl_t CTRL_FREEZE = '0;

  // Front end held while the mult/div owns EX; a bubble enters EX/MEM.
  localparam pipe_ctrl_t CTRL_MDU_STALL = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0,
    idex_flush: 1'b0, exmem_en: 1'b1, exmem_flush: 1'b1, memwb_en: 1'b1
  };

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Request and control bundle between the hazard/datapath side (master)
// and the stall/flush sequencer (slave).
interface pipeline_sequencer_if #(
  parameter int CNT_W = 16
);

  logic             hazard_req;
  logic             redirect;
  logic             mdu_start;
  logic             mem_wait;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             memwb_en;
  logic             mdu_busy;
  logic             mdu_done;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output hazard_req, redirect, mdu_start, mem_wait,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, mdu_busy, mdu_done, stall_cycles
  );

  modport slave (
    input  hazard_req, redirect, mdu_start, mem_wait,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, mdu_busy, mdu_done, stall_cycles
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, holding once the maximum is reached.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    if (reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central stall/flush sequencer for the 5-stage pipeline. Priority, highest
// first: memory wait, mult/div occupancy, load-use hazard, redirect.
module pipeline_sequencer
  import pipeline_pkg::*;
#(
  parameter int MDU_CYCLES = MDU_CYCLES_DEFAULT,
  parameter int CNT_W      = 16
) (
  input logic                 clk,
  input logic                 reset,
  pipeline_sequencer_if.slave bus
);

  state_t     state, next_state;
  logic [3:0] cnt, next_cnt;
  pipe_ctrl_t ctrl;
  logic       done;

  // State and remaining-stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Priority resolution into next state and register controls.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    next_state = state;
    next_cnt   = cnt;
    ctrl       = CTRL_RUN;
    done       = 1'b0;

    if (reset) begin
      // Outputs show RUN defaults for the whole reset, whatever the inputs.
      ctrl = CTRL_RUN;
    end else if (bus.mem_wait) begin
      // Full freeze; state and cnt hold, which stretches any MDU cycle.
      ctrl = CTRL_FREEZE;
    end else if (state == MDU && cnt != 4'd0) begin
      ctrl     = CTRL_MDU_STALL;
      next_cnt = cnt - 4'd1;
    end else if (state == RUN && bus.mdu_start) begin
      ctrl       = CTRL_MDU_STALL;
      next_cnt   = 4'(MDU_CYCLES - 2);
      next_state = MDU;
    end else begin
      // RUN without a new mult/div, or the MDU done cycle. In the done cycle
      // a still-high mdu_start is ignored: ID/EX advances and replaces it.
      if (state == MDU) begin
        done       = 1'b1;
        next_state = RUN;
      end
      if (bus.hazard_req) begin
        // A redirect alongside depends on the load; it is re-resolved later.
        ctrl.pc_en      = 1'b0;
        ctrl.ifid_en    = 1'b0;
        ctrl.idex_flush = 1'b1;
      end else if (bus.redirect) begin
        ctrl.ifid_flush = 1'b1;
      end
    end
  end

  assign bus.pc_en       = ctrl.pc_en;
  assign bus.ifid_en     = ctrl.ifid_en;
  assign bus.ifid_flush  = ctrl.ifid_flush;
  assign bus.idex_en     = ctrl.idex_en;
  assign bus.idex_flush  = ctrl.idex_flush;
  assign bus.exmem_en    = ctrl.exmem_en;
  assign bus.exmem_flush = ctrl.exmem_flush;
  assign bus.memwb_en    = ctrl.memwb_en;
  assign bus.mdu_busy    = (state == MDU) && !reset;
  assign bus.mdu_done    = done;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (!ctrl.pc_en),
    .count (bus.stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: a per-cycle vector table followed
// by hand-written reset-mid-MDU and counter-saturation sequences.
module tb_pipeline_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  pipeline_sequencer_if #(.CNT_W(16)) bus ();
  pipeline_sequencer_if #(.CNT_W(4))  bus_s ();

  pipeline_sequencer #(.MDU_CYCLES(4), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pipeline_sequencer #(.MDU_CYCLES(4), .CNT_W(4)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en}
  localparam logic [7:0] C_RUN    = 8'b1101_0101;
  localparam logic [7:0] C_HAZ    = 8'b0001_1101;
  localparam logic [7:0] C_REDIR  = 8'b1111_0101;
  localparam logic [7:0] C_STALL  = 8'b0000_0111;
  localparam logic [7:0] C_FREEZE = 8'b0000_0000;

  typedef struct {
    logic        hz, rd, ms, mw;
    logic [7:0]  ctrl;
    logic        busy, done;
    logic [15:0] stall;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs[NV];

  function automatic logic [7:0] ctrl_of_main();
    return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
            bus.idex_flush, bus.exmem_en, bus.exmem_flush, bus.memwb_en};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  initial begin
    // stall = counter value seen during that cycle (before its edge)
    //            hz    rd    ms    mw    ctrl      busy  done  stall
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, C_RUN,    1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, C_HAZ,    1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, C_RUN,    1'b0, 1'b0, 16'd1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, C_HAZ,    1'b0, 1'b0, 16'd1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, C_REDIR,  1'b0, 1'b0, 16'd2};
    // mult/div held from t: stalls t..t+2, done at t+3
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, C_STALL,  1'b0, 1'b0, 16'd2};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, C_STALL,  1'b1, 1'b0, 16'd3};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, C_STALL,  1'b1, 1'b0, 16'd4};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, C_RUN,    1'b1, 1'b1, 16'd5};
    // back-to-back mult/div
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, C_STALL,  1'b0, 1'b0, 16'd5};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, C_STALL,  1'b1, 1'b0, 16'd6};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, C_STALL,  1'b1, 1'b0, 16'd7};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, C_REDIR,  1'b1, 1'b1, 16'd8};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, C_RUN,    1'b0, 1'b0, 16'd8};
    // mem_wait at t+1 for two cycles: done moves to t+5
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, C_STALL,  1'b0, 1'b0, 16'd8};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, C_FREEZE, 1'b1, 1'b0, 16'd9};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, C_FREEZE, 1'b1, 1'b0, 16'd10};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, C_STALL,  1'b1, 1'b0, 16'd11};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, C_STALL,  1'b1, 1'b0, 16'd12};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, C_RUN,    1'b1, 1'b1, 16'd13};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, C_RUN,    1'b0, 1'b0, 16'd13};
    // mem_wait in the done cycle delays mdu_done
    vecs[21] = '{1'b0, 1'b0, 1'b1, 1'b0, C_STALL,  1'b0, 1'b0, 16'd13};
    vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b0, C_STALL,  1'b1, 1'b0, 16'd14};
    vecs[23] = '{1'b0, 1'b0, 1'b1, 1'b0, C_STALL,  1'b1, 1'b0, 16'd15};
    vecs[24] = '{1'b0, 1'b0, 1'b1, 1'b1, C_FREEZE, 1'b1, 1'b0, 16'd16};
    vecs[25] = '{1'b1, 1'b0, 1'b1, 1'b0, C_HAZ,    1'b1, 1'b1, 16'd17};
    vecs[26] = '{1'b0, 1'b0, 1'b0, 1'b0, C_RUN,    1'b0, 1'b0, 16'd18};
    // mem_wait outranks a hazard in RUN
    vecs[27] = '{1'b1, 1'b1, 1'b0, 1'b1, C_FREEZE, 1'b0, 1'b0, 16'd18};
    vecs[28] = '{1'b0, 1'b0, 1'b0, 1'b0, C_RUN,    1'b0, 1'b0, 16'd19};

    bus.hazard_req = 1'b0; bus.redirect = 1'b0;
    bus.mdu_start = 1'b0;  bus.mem_wait = 1'b0;
    bus_s.hazard_req = 1'b0; bus_s.redirect = 1'b0;
    bus_s.mdu_start = 1'b0;  bus_s.mem_wait = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_ctrl", 32'(ctrl_of_main()), 32'(C_RUN));
    check("reset_stall", 32'(bus.stall_cycles), 32'd0);
    reset = 1'b0;

    // Table: drive just after a rising edge, compare on the falling edge.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      bus.hazard_req = vecs[i].hz;
      bus.redirect   = vecs[i].rd;
      bus.mdu_start  = vecs[i].ms;
      bus.mem_wait   = vecs[i].mw;
      @(negedge clk);
      check($sformatf("v%0d_ctrl", i), 32'(ctrl_of_main()), 32'(vecs[i].ctrl));
      check($sformatf("v%0d_busy", i), 32'(bus.mdu_busy), 32'(vecs[i].busy));
      check($sformatf("v%0d_done", i), 32'(bus.mdu_done), 32'(vecs[i].done));
      check($sformatf("v%0d_stall", i), 32'(bus.stall_cycles), 32'(vecs[i].stall));
    end

    // Reset mid-MDU: start at cycle 0, reset asynchronously in cycle 1.
    @(posedge clk); #1;
    bus.mdu_start = 1'b1; bus.hazard_req = 1'b0;
    bus.redirect = 1'b0;  bus.mem_wait = 1'b0;
    @(posedge clk); #1;
    check("mid_mdu_busy", 32'(bus.mdu_busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_ctrl", 32'(ctrl_of_main()), 32'(C_RUN));
    check("rst_async_busy", 32'(bus.mdu_busy), 32'd0);
    check("rst_async_done", 32'(bus.mdu_done), 32'd0);
    check("rst_async_stall", 32'(bus.stall_cycles), 32'd0);
    bus.mdu_start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ctrl", 32'(ctrl_of_main()), 32'(C_RUN));
    check("post_rst_busy", 32'(bus.mdu_busy), 32'd0);

    // Saturation on the 4-bit instance: hazard held for 20 cycles.
    @(posedge clk); #1;
    bus_s.hazard_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("sat_c%0d", i), 32'(bus_s.stall_cycles),
            (i < 15) ? i : 15);
      @(posedge clk); #1;
    end
    bus_s.hazard_req = 1'b0;
    @(negedge clk);
    check("sat_hold", 32'(bus_s.stall_cycles), 32'd15);
    check("sat_pc_en", 32'(bus_s.pc_en), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
